// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin arbiter sharing one single-precision multiplier
//
// Purpose: NUM_REQ requesters present operand pairs on valid/ready channels. One
// request at a time is granted, its operands are driven to an external multiplier,
// the product is sampled MUL_LAT cycles later, and it is returned on a single
// response channel tagged with the requester index.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            per-requester operand handshake (ready one-hot or zero)
//   req_a/req_b                    packed operands, requester i at [32*i+31:32*i]
//   mul_a/mul_b                    operands to the shared multiplier
//   mul_result/mul_overflow        multiplier outputs
//   rsp_valid/rsp_ready            response handshake
//   rsp_id/rsp_result/rsp_overflow response payload
//   busy                           high whenever the FSM is not idle
//
// Build option: FP_MUL_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// instead of round-robin.

module fp_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 0,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    output logic [31:0]            mul_a,
    output logic [31:0]            mul_b,
    input  logic [31:0]            mul_result,
    input  logic                   mul_overflow,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [31:0]            rsp_result,
    output logic                   rsp_overflow,
    output logic                   busy
);

    localparam int CNT_W = 3;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       opa_q, opa_d;
    logic [31:0]       opb_q, opb_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       res_q, res_d;
    logic              ovf_q, ovf_d;
    logic [ID_W-1:0]   rr_base;
    logic              gnt_vld;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W-1:0]   scan_idx;

`ifdef FP_MUL_ARB_FIXED_PRIO_EN
    assign rr_base = '0;
`else
    logic [ID_W-1:0]   rr_q, rr_d;
    assign rr_base = rr_q;
`endif

    // Scan from rr_base upwards (mod NUM_REQ). Iterating downwards lets the
    // last match, i.e. the nearest to rr_base, win without a break.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_id   = '0;
        scan_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = ID_W'((int'(rr_base) + k) % NUM_REQ);
            if (req_valid[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = scan_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && gnt_vld) begin
            req_ready = NUM_REQ'(1) << gnt_id;
        end
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    opa_d   = req_a[32*gnt_id +: 32];
                    opb_d   = req_b[32*gnt_id +: 32];
                    id_d    = gnt_id;
                    cnt_d   = CNT_W'(MUL_LAT);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // cnt counts down the remaining multiplier latency; the
                // result is sampled in the cycle it reaches zero.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    res_d   = mul_result;
                    ovf_d   = mul_overflow;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
                    // Wrap explicitly so non-power-of-two NUM_REQ stays in range.
                    rr_d = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign mul_a        = opa_q;
    assign mul_b        = opb_q;
    assign rsp_valid    = (state_q == RESP);
    assign rsp_id       = id_q;
    assign rsp_result   = res_q;
    assign rsp_overflow = ovf_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb/tb_fp_mul_arbiter.sv - self-checking bench for fp_mul_arbiter

module tb_fp_mul_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [31:0]  mul_a;
    logic [31:0]  mul_b;
    logic [31:0]  mul_result;
    logic         mul_overflow;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_result;
    logic         rsp_overflow;
    logic         busy;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   glog_id[$];
    int   glog_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_mul_arbiter #(.NUM_REQ(NREQ), .MUL_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_overflow(mul_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
        .busy(busy)
    );

    // Reference single-precision multiply for normal operands (truncating);
    // returns {overflow, result}.
    function automatic logic [32:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] m;
        logic        s;
        int          e;
        s = a[31] ^ b[31];
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
        if (e <= 0)   return {1'b0, s, 31'h0};
        return {1'b0, s, e[7:0], m};
    endfunction

    // Multiplier model with a true LAT-cycle pipeline: sampling too early
    // returns the previous operation's product.
    logic [32:0] mul_comb;
    logic [32:0] mul_pipe [1:LAT];
    assign mul_comb = fmul(mul_a, mul_b);
    always @(posedge clk) begin
        mul_pipe[1] <= mul_comb;
        for (int k = 2; k <= LAT; k++) mul_pipe[k] <= mul_pipe[k-1];
    end
    assign mul_overflow = mul_pipe[LAT][32];
    assign mul_result   = mul_pipe[LAT][31:0];

    task automatic monitor();
        exp_t        e;
        logic [32:0] r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i] && req_valid[i]) begin
                        r = fmul(req_a[32*i +: 32], req_b[32*i +: 32]);
                        e.id  = 2'(i);
                        e.res = r[31:0];
                        e.ovf = r[32];
                        sb.push_back(e);
                        glog_id.push_back(i);
                        glog_cyc.push_back(cyc);
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    tests++;
                    if (sb.size() == 0) begin
                        failed++;
                        $display("FAIL rsp_unexpected: got id=%0d result=%h, required no response", rsp_id, rsp_result);
                    end else begin
                        e = sb.pop_front();
                        if (rsp_id !== e.id || rsp_result !== e.res || rsp_overflow !== e.ovf) begin
                            failed++;
                            $display("FAIL rsp_scoreboard: got id=%0d result=%h ovf=%b, required id=%0d result=%h ovf=%b",
                                     rsp_id, rsp_result, rsp_overflow, e.id, e.res, e.ovf);
                        end
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0) begin
            failed++;
            $display("FAIL reset_ctrl: got busy=%b rsp_valid=%b req_ready=%b, required 0 0 0000", busy, rsp_valid, req_ready);
        end
        tests++;
        if (mul_a !== 32'h0 || mul_b !== 32'h0 || rsp_result !== 32'h0 || rsp_id !== 2'd0 || rsp_overflow !== 1'b0) begin
            failed++;
            $display("FAIL reset_data: got mul_a=%h mul_b=%h result=%h id=%0d ovf=%b, required all 0",
                     mul_a, mul_b, rsp_result, rsp_id, rsp_overflow);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_latency(input int id, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res);
        logic [3:0] onehot;
        int         t0;
        bit         seen;
        onehot = 4'b0001 << id;
        @(posedge clk); #1;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_valid = onehot;
        rsp_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (req_ready !== onehot) begin
            failed++;
            $display("FAIL grant_same_cycle: got req_ready=%b, required %b", req_ready, onehot);
        end
        t0 = cyc;
        @(posedge clk); #1;
        req_valid = 4'b0;
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            tests++;
            if (mul_a !== a || mul_b !== b || busy !== 1'b1 || req_ready !== 4'b0) begin
                failed++;
                $display("FAIL exec_hold: got mul_a=%h mul_b=%h busy=%b ready=%b, required %h %h 1 0000",
                         mul_a, mul_b, busy, req_ready, a, b);
            end
        end
        tests++;
        if (!seen) begin
            failed++;
            $display("FAIL rsp_timeout: got no rsp_valid, required rsp_valid within 30 cycles");
        end else if (cyc - t0 != 2 + LAT) begin
            failed++;
            $display("FAIL latency: got %0d cycles, required %0d", cyc - t0, 2 + LAT);
        end
        tests++;
        if (rsp_id !== 2'(id) || rsp_result !== exp_res || rsp_overflow !== 1'b0) begin
            failed++;
            $display("FAIL rsp_fields: got id=%0d result=%h ovf=%b, required id=%0d result=%h ovf=0",
                     rsp_id, rsp_result, rsp_overflow, id, exp_res);
        end
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || mul_a !== a) begin
            failed++;
            $display("FAIL after_handshake: got rsp_valid=%b busy=%b mul_a=%h, required 0 0 %h", rsp_valid, busy, mul_a, a);
        end
    endtask

    task automatic test_round_robin();
        int exp_id;
        do_reset();
        glog_id.delete();
        glog_cyc.delete();
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = {1'($urandom_range(0, 1)), 8'(110 + $urandom_range(0, 30)), 23'($urandom)};
            req_b[32*i +: 32] = {1'($urandom_range(0, 1)), 8'(110 + $urandom_range(0, 30)), 23'($urandom)};
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int n = 0; n < 200 && glog_id.size() < 5; n++) @(negedge clk);
        @(posedge clk); #1;
        req_valid = 4'b0;
        tests++;
        if (glog_id.size() < 5) begin
            failed++;
            $display("FAIL rr_timeout: got %0d grants, required 5", glog_id.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
                exp_id = 0;
`else
                exp_id = k % NREQ;
`endif
                tests++;
                if (glog_id[k] != exp_id) begin
                    failed++;
                    $display("FAIL rr_order[%0d]: got grant %0d, required %0d", k, glog_id[k], exp_id);
                end
            end
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (glog_cyc[k+1] - glog_cyc[k] != 3 + LAT) begin
                    failed++;
                    $display("FAIL rr_spacing[%0d]: got %0d cycles, required %0d", k, glog_cyc[k+1] - glog_cyc[k], 3 + LAT);
                end
            end
        end
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL rr_drain: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_a[96 +: 32] = 32'h3FC00000;
        req_b[96 +: 32] = 32'h40000000;
        req_valid = 4'b1000;
        @(negedge clk);
        tests++;
        if (req_ready !== 4'b1000) begin
            failed++;
            $display("FAIL bp_grant: got req_ready=%b, required 1000", req_ready);
        end
        @(posedge clk); #1;
        req_a[32 +: 32] = 32'h40400000;
        req_b[32 +: 32] = 32'h40400000;
        req_valid = 4'b0010;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            tests++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_result !== 32'h40400000 || rsp_overflow !== 1'b0 ||
                req_ready !== 4'b0 || busy !== 1'b1) begin
                failed++;
                $display("FAIL bp_hold[%0d]: got valid=%b id=%0d result=%h ovf=%b ready=%b, required 1 3 40400000 0 0000",
                         n, rsp_valid, rsp_id, rsp_result, rsp_overflow, req_ready);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (req_ready !== 4'b0010) begin
            failed++;
            $display("FAIL bp_first_idle_grant: got req_ready=%b, required 0010", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 4'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL bp_drain: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_exec();
        @(posedge clk); #1;
        req_a[64 +: 32] = 32'h40000000;
        req_b[64 +: 32] = 32'h40000000;
        req_valid = 4'b0100;
        @(negedge clk);
        tests++;
        if (req_ready !== 4'b0100) begin
            failed++;
            $display("FAIL rx_grant: got req_ready=%b, required 0100", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 4'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0) begin
            failed++;
            $display("FAIL rx_after_reset: got busy=%b rsp_valid=%b ready=%b, required 0 0 0000", busy, rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_a[0 +: 32] = 32'h40400000;
        req_b[0 +: 32] = 32'h3F800000;
        req_valid = 4'b0101;
        @(negedge clk);
        tests++;
        if (req_ready !== 4'b0001) begin
            failed++;
            $display("FAIL rx_first_grant: got req_ready=%b, required 0001", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 4'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL rx_drain: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_overflow();
        bit seen;
        @(posedge clk); #1;
        req_a[96 +: 32] = 32'h7F000000;
        req_b[96 +: 32] = 32'h40000000;
        req_valid = 4'b1000;
        @(posedge clk); #1;
        req_valid = 4'b0;
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen || rsp_overflow !== 1'b1 || rsp_result !== 32'h7F800000 || rsp_id !== 2'd3) begin
            failed++;
            $display("FAIL overflow: got seen=%b ovf=%b result=%h id=%0d, required 1 1 7f800000 3",
                     seen, rsp_overflow, rsp_result, rsp_id);
        end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_latency(0, 32'h40000000, 32'h40400000, 32'h40C00000);
        test_latency(2, 32'hC0000000, 32'h40800000, 32'hC1000000);
        test_round_robin();
        test_backpressure();
        test_reset_exec();
        test_overflow();
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL sb_empty: got %0d pending responses, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
